// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                            |
// | Description : Round-robin arbiter sharing one UART transmitter between   |
// |               NREQ requesters. Launches the winning word into the UART,  |
// |               follows uart_busy until the frame ends, then inserts an    |
// |               inter-frame gap before arbitrating again. A missing busy   |
// |               response after launch raises a one-cycle err_timeout.      |
// | Options     : `define UART_ARB_PRIO0_EN gives requester 0 fixed highest  |
// |               priority; the other requesters stay round-robin.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
    parameter int DEPTH        = 5,
    parameter int NREQ         = 4,
    parameter int GAP          = 2,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DEPTH-1:0]    req_data,
    output logic [NREQ-1:0]          ack,
    input  logic                     uart_busy,
    output logic                     uart_enable,
    output logic [DEPTH-1:0]         uart_data,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     active,
    output logic                     err_timeout
);

    localparam int c_OW      = $clog2(NREQ);
    localparam int c_CNT_MAX = (GAP > BUSY_TIMEOUT) ? GAP : BUSY_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [NREQ-1:0]    c_ONE      = NREQ'(1);
    localparam logic [c_OW-1:0]    c_OWN_RST  = c_OW'(NREQ - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_BUSY = 2'd1;
    localparam logic [1:0] c_WAIT_DONE = 2'd2;
    localparam logic [1:0] c_GAP       = 2'd3;

    // State after a finished or abandoned frame: skip GAP entirely when it is zero
    localparam logic [1:0] c_POST_FRAME = (GAP == 0) ? c_IDLE : c_GAP;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [NREQ-1:0]    r_ack;
    logic               r_uart_enable;
    logic [DEPTH-1:0]   r_uart_data;
    logic [c_OW-1:0]    r_owner;
    logic               r_err_timeout;

    logic [c_OW:0]      w_pick;
    logic               w_found;
    logic [c_OW-1:0]    w_idx;
    logic               w_upd_owner;
    logic [DEPTH-1:0]   w_word;

    // First set bit of r searching upward from last+1 with wrap; returns {found, index}
    function automatic logic [c_OW:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [c_OW-1:0] last);
        logic [c_OW:0] w_res;
        int            w_pos;
        w_res = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = int'(last) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (!w_res[c_OW] && (((r >> w_pos) & c_ONE) != '0)) begin
                w_res = {1'b1, c_OW'(w_pos)};
            end
        end
        return w_res;
    endfunction

    // Grant selection for the IDLE sample
    always_comb begin
        w_found     = 1'b0;
        w_idx       = '0;
        w_upd_owner = 1'b1;
`ifdef UART_ARB_PRIO0_EN
        // Requester 0 pre-empts the rotation and leaves the rotation pointer alone
        w_pick = rr_pick({req[NREQ-1:1], 1'b0}, r_owner);
        if (req[0]) begin
            w_found     = 1'b1;
            w_idx       = '0;
            w_upd_owner = 1'b0;
        end else begin
            w_found = w_pick[c_OW];
            w_idx   = w_pick[c_OW-1:0];
        end
`else
        w_pick  = rr_pick(req, r_owner);
        w_found = w_pick[c_OW];
        w_idx   = w_pick[c_OW-1:0];
`endif
    end

    // Word of the selected requester
    assign w_word = DEPTH'(req_data >> (int'(w_idx) * DEPTH));

    // Arbitration / frame-tracking FSM with registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_ack         <= '0;
            r_uart_enable <= 1'b0;
            r_uart_data   <= '0;
            r_owner       <= c_OWN_RST;
            r_err_timeout <= 1'b0;
        end else begin
            r_ack         <= '0;
            r_uart_enable <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_uart_data   <= w_word;
                        r_ack         <= c_ONE << w_idx;
                        r_uart_enable <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= c_WAIT_BUSY;
                        if (w_upd_owner) begin
                            r_owner <= w_idx;
                        end
                    end
                end
                c_WAIT_BUSY: begin
                    // busy seen during the launch cycle itself is stale, so ignore it
                    if (uart_busy && !r_uart_enable) begin
                        r_state <= c_WAIT_DONE;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= c_POST_FRAME;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_WAIT_DONE: begin
                    if (!uart_busy) begin
                        r_cnt   <= '0;
                        r_state <= c_POST_FRAME;
                    end
                end
                c_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign ack         = r_ack;
    assign uart_enable = r_uart_enable;
    assign uart_data   = r_uart_data;
    assign owner       = r_owner;
    assign err_timeout = r_err_timeout;
    assign active      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                         |
// | Description : Self-checking bench for uart_tx_arbiter (NREQ=4, DEPTH=5,  |
// |               GAP=2, BUSY_TIMEOUT=4). Cycle table plus directed          |
// |               sequences for reset, fairness and priority.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [3:0]  req       = '0;
    logic [19:0] req_data  = {5'h07, 5'h13, 5'h0A, 5'h15};
    logic        tb_busy   = 1'b0;
    logic        use_model = 1'b0;
    logic [2:0]  r_mcnt;
    logic        w_uart_busy;

    logic [3:0]  ack;
    logic        uart_enable;
    logic [4:0]  uart_data;
    logic [1:0]  owner;
    logic        active;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] req;
        logic       busy;
        logic [3:0] ack;
        logic       en;
        logic [4:0] data;
        logic [1:0] own;
        logic       act;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    uart_tx_arbiter #(
        .DEPTH        (5),
        .NREQ         (4),
        .GAP          (2),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .uart_busy   (w_uart_busy),
        .uart_enable (uart_enable),
        .uart_data   (uart_data),
        .owner       (owner),
        .active      (active),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Simple UART stand-in: busy for three cycles starting the cycle after enable
    always @(posedge clk) begin
        if (rst)              r_mcnt <= '0;
        else if (uart_enable) r_mcnt <= 3'd3;
        else if (r_mcnt != 0) r_mcnt <= r_mcnt - 3'd1;
    end

    assign w_uart_busy = use_model ? (r_mcnt != 0) : tb_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic b, input logic [3:0] a, input logic e,
                       input logic [4:0] d, input logic [1:0] o, input logic ac, input logic er);
        vec_t v;
        v.req = r; v.busy = b; v.ack = a; v.en = e;
        v.data = d; v.own = o; v.act = ac; v.err = er;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; tb_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Hold request pattern r until some ack arrives (bounded wait)
    task automatic run_until_ack(input logic [3:0] r, output logic [3:0] got, output logic [4:0] dat);
        got = '0;
        dat = '0;
        for (int n = 0; n < 60 && got == '0; n++) begin
            @(negedge clk);
            req = r;
            @(posedge clk);
            #1;
            if (ack != '0) begin
                got = ack;
                dat = uart_data;
            end
        end
        check("grant_wait", {31'd0, got != '0}, 32'd1);
    endtask

    initial begin
        logic [3:0] got;
        logic [4:0] dat;
        logic [3:0] pending;
        logic [4:0] words [4];
        logic [3:0] exp_prio;
        words[0] = 5'h15; words[1] = 5'h0A; words[2] = 5'h13; words[3] = 5'h07;

        //   req     busy  ack     en  data   own  act err
        add(4'b0000, 1'b0, 4'b0000, 0, 5'h00, 2'd3, 0, 0); // reset state
        add(4'b0001, 1'b0, 4'b0001, 1, 5'h15, 2'd0, 1, 0); // grant 0
        add(4'b0000, 1'b0, 4'b0000, 0, 5'h15, 2'd0, 1, 0); // launch cycle
        for (int i = 0; i < 10; i++)
            add(4'b0000, 1'b1, 4'b0000, 0, 5'h15, 2'd0, 1, 0); // busy 10 cycles
        add(4'b0000, 1'b0, 4'b0000, 0, 5'h15, 2'd0, 1, 0); // -> GAP
        add(4'b0100, 1'b0, 4'b0000, 0, 5'h15, 2'd0, 1, 0); // GAP, req held off
        add(4'b0100, 1'b0, 4'b0000, 0, 5'h15, 2'd0, 0, 0); // -> IDLE
        add(4'b0100, 1'b0, 4'b0100, 1, 5'h13, 2'd2, 1, 0); // grant 2
        add(4'b0011, 1'b0, 4'b0000, 0, 5'h13, 2'd2, 1, 0);
        add(4'b0011, 1'b1, 4'b0000, 0, 5'h13, 2'd2, 1, 0);
        add(4'b0011, 1'b0, 4'b0000, 0, 5'h13, 2'd2, 1, 0);
        add(4'b0011, 1'b0, 4'b0000, 0, 5'h13, 2'd2, 1, 0);
        add(4'b0011, 1'b0, 4'b0000, 0, 5'h13, 2'd2, 0, 0);
        add(4'b0011, 1'b0, 4'b0001, 1, 5'h15, 2'd0, 1, 0); // wrap 2 -> 0
        add(4'b0010, 1'b0, 4'b0000, 0, 5'h15, 2'd0, 1, 0);
        add(4'b0010, 1'b1, 4'b0000, 0, 5'h15, 2'd0, 1, 0);
        add(4'b0010, 1'b0, 4'b0000, 0, 5'h15, 2'd0, 1, 0);
        add(4'b0010, 1'b0, 4'b0000, 0, 5'h15, 2'd0, 1, 0);
        add(4'b0010, 1'b0, 4'b0000, 0, 5'h15, 2'd0, 0, 0);
        add(4'b0010, 1'b0, 4'b0010, 1, 5'h0A, 2'd1, 1, 0); // grant 1
        for (int i = 0; i < 3; i++)
            add(4'b0000, 1'b0, 4'b0000, 0, 5'h0A, 2'd1, 1, 0); // no busy
        add(4'b0000, 1'b0, 4'b0000, 0, 5'h0A, 2'd1, 1, 1); // timeout pulse
        add(4'b0000, 1'b0, 4'b0000, 0, 5'h0A, 2'd1, 1, 0); // GAP
        add(4'b0000, 1'b0, 4'b0000, 0, 5'h0A, 2'd1, 0, 0); // IDLE
        add(4'b1000, 1'b0, 4'b1000, 1, 5'h07, 2'd3, 1, 0); // grant 3
        add(4'b0000, 1'b0, 4'b0000, 0, 5'h07, 2'd3, 1, 0);
        add(4'b0000, 1'b1, 4'b0000, 0, 5'h07, 2'd3, 1, 0); // WAIT_DONE

        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            req     = vecs[i].req;
            tb_busy = vecs[i].busy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {18'd0, ack, uart_enable, uart_data, owner, active, err_timeout},
                  {18'd0, vecs[i].ack, vecs[i].en, vecs[i].data, vecs[i].own, vecs[i].act, vecs[i].err});
        end

        // Reset during WAIT_DONE
        @(negedge clk);
        rst = 1'b1; req = '0; tb_busy = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_en", {31'd0, uart_enable}, 32'd0);
        check("rst_data", {27'd0, uart_data}, 32'd0);
        check("rst_owner", {30'd0, owner}, 32'd3);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_err", {31'd0, err_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0; tb_busy = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ack", {28'd0, ack}, 32'd0);
        check("post_rst_en", {31'd0, uart_enable}, 32'd0);
        @(negedge clk);
        req = 4'b0100;
        @(posedge clk);
        #1;
        check("rst_grant_ack", {28'd0, ack}, 32'h4);
        check("rst_grant_en", {31'd0, uart_enable}, 32'd1);
        check("rst_grant_owner", {30'd0, owner}, 32'd2);
        check("rst_grant_data", {27'd0, uart_data}, 32'h13);
        @(negedge clk);
        req = '0;
        @(posedge clk);
        #1;
        check("rst_nostray_ack", {28'd0, ack}, 32'd0);
        check("rst_nostray_en", {31'd0, uart_enable}, 32'd0);

        // Fairness: all four requesting, each drops after its own ack
        do_reset();
        use_model = 1'b1;
        pending   = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            run_until_ack(pending, got, dat);
            check($sformatf("fair_ack%0d", n), {28'd0, got}, 32'd1 << n);
            check($sformatf("fair_data%0d", n), {27'd0, dat}, {27'd0, words[n]});
            pending = pending & ~got;
        end

        // Priority: requester 0 just served, then 0,1,2 all request
        do_reset();
        run_until_ack(4'b0001, got, dat);
        check("prio_first", {28'd0, got}, 32'h1);
`ifdef UART_ARB_PRIO0_EN
        exp_prio = 4'b0001;
`else
        exp_prio = 4'b0010;
`endif
        run_until_ack(4'b0111, got, dat);
        check("prio_second", {28'd0, got}, {28'd0, exp_prio});
        @(negedge clk);
        req = '0;
        repeat (15) @(negedge clk);
        check("final_idle", {31'd0, active}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
